// File: rtl/mc_data_memory_responder.sv
// Memory-side responder for the multi-cycle RISC-V core.
// Serves one load/store/fetch at a time over a req/ready handshake.
// Inserts WAIT_CYCLES wait states, writes byte lanes for SB/SH/SW,
// sign/zero-extends loads and flags misaligned or illegal requests.
// The word array lives inside the block and is never cleared by reset.
module mc_data_memory_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
   localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] wait_cnt;

   logic          lat_we;
   logic          lat_err;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [2:0]    lat_funct3;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          req_err;
   logic          accept;
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;
   logic [3:0]    lane_en;
   logic [31:0]   lane_data;

   assign accept   = (state == S_IDLE) && req;
   assign word_idx = lat_addr[AW+1:2];
   assign rd_word  = mem[word_idx];

   // Classify the incoming request: illegal size codes, stores of unsigned sizes, misalignment
   always_comb begin
      req_err = 1'b0;
      case (funct3)
         3'b000:  req_err = 1'b0;
         3'b001:  req_err = addr[0];
         3'b010:  req_err = (addr[1:0] != 2'b00);
         3'b100:  req_err = we;
         3'b101:  req_err = we | addr[0];
         default: req_err = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: errors skip straight to the response, zero wait skips WAIT
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (req_err) begin
                  state_next = S_RESP;
               end else if (WAIT_CYCLES > 0) begin
                  state_next = S_WAIT;
               end else begin
                  state_next = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == '0) begin
               state_next = S_ACCESS;
            end
         end
         S_ACCESS: state_next = S_RESP;
         S_RESP:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      busy  = (state != S_IDLE);
      ready = (state == S_RESP);
      err   = (state == S_RESP) && lat_err;
   end

   // Request capture, wait counter and load result register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_funct3 <= '0;
         wait_cnt   <= '0;
         rdata      <= '0;
      end else begin
         if (accept) begin
            lat_we     <= we;
            lat_err    <= req_err;
            lat_addr   <= addr;
            lat_wdata  <= wdata;
            lat_funct3 <= funct3;
            if (!req_err) begin
               wait_cnt <= WAIT_LOAD;
            end
         end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if ((state == S_ACCESS) && !lat_we) begin
            rdata <= load_val;
         end
      end
   end

   // Pick the addressed byte/half from the stored word and extend it
   always_comb begin
      case (lat_addr[1:0])
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (lat_funct3)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_val = {24'h0, byte_sel};
         3'b101:  load_val = {16'h0, half_sel};
         default: load_val = rd_word;
      endcase
   end

   // Byte-lane enables and replicated store data for the latched store
   always_comb begin
      lane_en   = 4'b0000;
      lane_data = lat_wdata;
      case (lat_funct3)
         3'b000: begin
            lane_en   = 4'b0001 << lat_addr[1:0];
            lane_data = {4{lat_wdata[7:0]}};
         end
         3'b001: begin
            lane_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{lat_wdata[15:0]}};
         end
         3'b010:  lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

   // Array write on the edge leaving ACCESS; only enabled lanes change
   always_ff @(posedge clk) begin
      if ((state == S_ACCESS) && lat_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mc_data_memory_responder.sv
// Directed bench for mc_data_memory_responder.
// Two instances share the stimulus: one with two wait states, one with none.
// A vector table covers loads/stores/errors; hand-written sequences cover
// busy/req hold behaviour and reset during an access.
module tb_mc_data_memory_responder;

   logic        clk;
   logic        reset;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  funct3;

   logic        busy_slow, ready_slow, err_slow;
   logic [31:0] rdata_slow;
   logic        busy_fast, ready_fast, err_fast;
   logic [31:0] rdata_fast;

   logic        sel_fast;
   logic        o_busy, o_ready, o_err;
   logic [31:0] o_rdata;

   int tests_run;
   int tests_failed;

   typedef struct {
      bit          fast;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
      logic [31:0] exp_rdata;
      bit          exp_err;
      string       name;
   } vec_t;

   vec_t vecs[$];

   mc_data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_slow (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .funct3(funct3), .busy(busy_slow), .ready(ready_slow), .rdata(rdata_slow), .err(err_slow)
   );

   mc_data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_fast (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .funct3(funct3), .busy(busy_fast), .ready(ready_fast), .rdata(rdata_fast), .err(err_fast)
   );

   assign o_busy  = sel_fast ? busy_fast  : busy_slow;
   assign o_ready = sel_fast ? ready_fast : ready_slow;
   assign o_err   = sel_fast ? err_fast   : err_slow;
   assign o_rdata = sel_fast ? rdata_fast : rdata_slow;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic addVec(input bit fast, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic [31:0] er, input bit ee, input string nm);
      vec_t v;
      v.fast = fast; v.we = w; v.addr = a; v.wdata = d; v.funct3 = f3;
      v.exp_rdata = er; v.exp_err = ee; v.name = nm;
      vecs.push_back(v);
   endtask

   // Issue one request, scramble inputs after acceptance, wait for ready and check it
   task automatic applyStimulus(input int idx);
      vec_t v;
      int   edges;
      int   exp_cycles;
      v = vecs[idx];
      sel_fast = v.fast;
      @(negedge clk);
      we = v.we; addr = v.addr; wdata = v.wdata; funct3 = v.funct3; req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0; we = ~v.we; addr = 32'hFFFF_FFFC; wdata = ~v.wdata; funct3 = 3'b111;
      edges = 0;
      @(negedge clk);
      while (!o_ready && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      if (v.exp_err) exp_cycles = 1;
      else           exp_cycles = v.fast ? 2 : 4;
      checkOutput({v.name, " ready"}, {31'b0, o_ready}, 32'd1);
      checkOutput({v.name, " latency"}, edges + 1, exp_cycles);
      checkOutput({v.name, " rdata"}, o_rdata, v.exp_rdata);
      checkOutput({v.name, " err"}, {31'b0, o_err}, {31'b0, v.exp_err});
      checkOutput({v.name, " busy_in_resp"}, {31'b0, o_busy}, 32'd1);
      @(negedge clk);
      checkOutput({v.name, " ready_pulse"}, {31'b0, o_ready}, 32'd0);
   endtask

   initial begin
      int   cycles;
      int   pulses;
      bit   busy_ok;
      logic [31:0] got_rdata;
      tests_run = 0;
      tests_failed = 0;
      sel_fast = 1'b0;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; funct3 = 3'b010;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy_slow",  {31'b0, busy_slow},  32'd0);
      checkOutput("reset ready_slow", {31'b0, ready_slow}, 32'd0);
      checkOutput("reset err_slow",   {31'b0, err_slow},   32'd0);
      checkOutput("reset rdata_slow", rdata_slow, 32'h0);
      checkOutput("reset busy_fast",  {31'b0, busy_fast},  32'd0);
      checkOutput("reset rdata_fast", rdata_fast, 32'h0);
      reset = 1'b0;

      addVec(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h00000000, 0, "SW 0x10");
      addVec(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0, "LW 0x10");
      addVec(0, 1, 32'h11, 32'h00000055, 3'b000, 32'hDEADBEEF, 0, "SB 0x11");
      addVec(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 0, "LW 0x10 after SB");
      addVec(0, 0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 0, "LB 0x13");
      addVec(0, 0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 0, "LBU 0x13");
      addVec(0, 0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 0, "LH 0x12");
      addVec(0, 0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 0, "LHU 0x12");
      addVec(0, 0, 32'h12, 32'h0,        3'b010, 32'h0000DEAD, 1, "LW 0x12 misaligned");
      addVec(0, 1, 32'h11, 32'h00001234, 3'b001, 32'h0000DEAD, 1, "SH 0x11 misaligned");
      addVec(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 0, "LW 0x10 after errors");
      addVec(0, 0, 32'h10, 32'h0,        3'b011, 32'hDEAD55EF, 1, "funct3 011");
      addVec(0, 0, 32'h10, 32'h0,        3'b000, 32'hFFFFFFEF, 0, "LB 0x10");
      addVec(0, 0, 32'h10, 32'h0,        3'b001, 32'h000055EF, 0, "LH 0x10");
      addVec(0, 1, 32'h10, 32'h000000AA, 3'b100, 32'h000055EF, 1, "store funct3 100");
      addVec(0, 1, 32'h20, 32'h00000000, 3'b010, 32'h000055EF, 0, "SW 0x20");
      addVec(0, 1, 32'h22, 32'h0000BEEF, 3'b001, 32'h000055EF, 0, "SH 0x22");
      addVec(0, 0, 32'h20, 32'h0,        3'b010, 32'hBEEF0000, 0, "LW 0x20");
      addVec(0, 0, 32'h22, 32'h0,        3'b001, 32'hFFFFBEEF, 0, "LH 0x22");
      addVec(0, 1, 32'h30, 32'h00000000, 3'b010, 32'hFFFFBEEF, 0, "SW 0x30");
      addVec(1, 1, 32'h1000, 32'hA5A5A5A5, 3'b010, 32'hFFFFBEEF, 0, "fast SW 0x1000");
      addVec(1, 0, 32'h0,    32'h0,        3'b010, 32'hA5A5A5A5, 0, "fast LW 0x0 wrap");
      addVec(1, 0, 32'h1003, 32'h0,        3'b000, 32'hFFFFFFA5, 0, "fast LB 0x1003");
      addVec(1, 0, 32'h2,    32'h0,        3'b101, 32'h0000A5A5, 0, "fast LHU 0x2");

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(i);
      end

      // Busy handling: req held and address changed while the request is in flight
      sel_fast = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      we = 1'b0; addr = 32'h10; funct3 = 3'b010; req = 1'b1;
      @(posedge clk);
      #1;
      addr = 32'h20;
      busy_ok = 1'b1;
      pulses = 0;
      cycles = 0;
      got_rdata = '0;
      @(negedge clk);
      while (cycles < 20) begin
         if (!o_busy) busy_ok = 1'b0;
         if (o_ready) begin
            pulses++;
            got_rdata = o_rdata;
            break;
         end
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      checkOutput("hold busy_through_resp", {31'b0, busy_ok}, 32'd1);
      checkOutput("hold latency", cycles + 1, 32'd4);
      checkOutput("hold rdata", got_rdata, 32'hDEAD55EF);
      @(negedge clk);
      checkOutput("hold no_accept_in_resp", {31'b0, o_busy}, 32'd0);
      req = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (o_ready) pulses++;
      end
      checkOutput("hold single_response", pulses, 32'd1);

      // Reset while the store sits in ACCESS: it must not reach the array
      @(negedge clk);
      we = 1'b1; addr = 32'h30; wdata = 32'h12345678; funct3 = 3'b010; req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort busy",  {31'b0, o_busy},  32'd0);
      checkOutput("abort ready", {31'b0, o_ready}, 32'd0);
      checkOutput("abort err",   {31'b0, o_err},   32'd0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_ready) pulses++;
      end
      checkOutput("abort no_ready", pulses, 32'd0);
      addVec(0, 0, 32'h30, 32'h0, 3'b010, 32'h00000000, 0, "LW 0x30 after abort");
      applyStimulus(vecs.size() - 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
